// File: rtl/pattern_tx.sv
// rtl/pattern_tx.sv - serial pattern transmitter, MSB-first, with repeat count
// Optional one-cycle frame gap between repetitions when PATTERN_TX_GAP_EN is defined.
module pattern_tx #(
  parameter int WIDTH = 5,
  parameter int REP_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] pattern_in,
  input  logic [REP_W-1:0] repeat_cnt,
  input  logic             hold,
  input  logic             abort,
  output logic             data_out,
  output logic             data_valid,
  output logic             busy,
  output logic             done
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] MSB_IDX = IDX_W'(WIDTH - 1);

`ifdef PATTERN_TX_GAP_EN
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;
`else
  typedef enum logic {S_IDLE, S_SHIFT} state_t;
`endif

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [REP_W-1:0] rep_q, rep_d;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic             data_out_q, data_out_d;
  logic             data_valid_q, data_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [IDX_W-1:0] idx_dec;

  assign idx_dec = idx_q - 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      idx_q        <= MSB_IDX;
      rep_q        <= '0;
      pat_q        <= '0;
      data_out_q   <= 1'b0;
      data_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      rep_q        <= rep_d;
      pat_q        <= pat_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  // idx_q names the bit currently on data_out; hold leaves everything but data_valid untouched.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    rep_d        = rep_q;
    pat_d        = pat_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    busy_d       = busy_q;
    done_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (load && !abort) begin
          pat_d        = pattern_in;
          rep_d        = repeat_cnt;
          idx_d        = MSB_IDX;
          data_out_d   = pattern_in[WIDTH-1];
          data_valid_d = 1'b1;
          busy_d       = 1'b1;
          state_d      = S_SHIFT;
        end
      end

      S_SHIFT: begin
        if (abort) begin
          state_d = S_IDLE;
          idx_d   = MSB_IDX;
          rep_d   = '0;
          busy_d  = 1'b0;
        end else if (!hold) begin
          if (idx_q != '0) begin
            idx_d        = idx_dec;
            data_out_d   = pat_q[idx_dec];
            data_valid_d = 1'b1;
          end else if (rep_q != '0) begin
            rep_d = rep_q - 1'b1;
`ifdef PATTERN_TX_GAP_EN
            state_d    = S_GAP;
            data_out_d = 1'b0;
`else
            idx_d        = MSB_IDX;
            data_out_d   = pat_q[WIDTH-1];
            data_valid_d = 1'b1;
`endif
          end else begin
            state_d = S_IDLE;
            idx_d   = MSB_IDX;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end

`ifdef PATTERN_TX_GAP_EN
      S_GAP: begin
        if (abort) begin
          state_d = S_IDLE;
          idx_d   = MSB_IDX;
          rep_d   = '0;
          busy_d  = 1'b0;
        end else if (!hold) begin
          state_d      = S_SHIFT;
          idx_d        = MSB_IDX;
          data_out_d   = pat_q[WIDTH-1];
          data_valid_d = 1'b1;
        end
      end
`endif

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_pattern_tx.sv
// tb/tb_pattern_tx.sv - directed and randomized bench for pattern_tx
// Reference model: a queue of pending serial symbols per transfer (2 = frame gap).
module tb_pattern_tx;

  localparam int WIDTH = 5;
  localparam int REP_W = 4;

  logic             clk;
  logic             rst;
  logic             load;
  logic [WIDTH-1:0] pattern_in;
  logic [REP_W-1:0] repeat_cnt;
  logic             hold;
  logic             abort;
  logic             data_out;
  logic             data_valid;
  logic             busy;
  logic             done;

  pattern_tx #(.WIDTH(WIDTH), .REP_W(REP_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .pattern_in (pattern_in),
    .repeat_cnt (repeat_cnt),
    .hold       (hold),
    .abort      (abort),
    .data_out   (data_out),
    .data_valid (data_valid),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;

  int   q[$];
  logic m_busy   = 1'b0;
  logic exp_valid = 1'b0;
  logic exp_busy  = 1'b0;
  logic exp_done  = 1'b0;
  logic exp_data  = 1'b0;
  logic data_chk  = 1'b1;

  task automatic cmp(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s cycle %0d: observed %b expected %b", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_all();
    cmp("data_valid", data_valid, exp_valid);
    cmp("busy", busy, exp_busy);
    cmp("done", done, exp_done);
    if (data_chk) cmp("data_out", data_out, exp_data);
  endtask

  task automatic model_reset();
    q.delete();
    m_busy    = 1'b0;
    exp_valid = 1'b0;
    exp_busy  = 1'b0;
    exp_done  = 1'b0;
    exp_data  = 1'b0;
    data_chk  = 1'b1;
  endtask

  task automatic model_step();
    int v;
    if (!rst) begin
      model_reset();
      return;
    end
    exp_done = 1'b0;
    if (m_busy) begin
      if (abort) begin
        q.delete();
        m_busy = 1'b0; exp_busy = 1'b0; exp_valid = 1'b0; data_chk = 1'b0;
      end else if (hold) begin
        exp_valid = 1'b0;
      end else if (q.size() == 0) begin
        m_busy = 1'b0; exp_busy = 1'b0; exp_valid = 1'b0; exp_done = 1'b1; data_chk = 1'b0;
      end else begin
        v = q.pop_front();
        exp_valid = (v != 2);
        exp_data  = (v == 1);
        data_chk  = 1'b1;
      end
    end else begin
      exp_valid = 1'b0; exp_busy = 1'b0; data_chk = 1'b0;
      if (load && !abort) begin
        q.delete();
        for (int r = 0; r <= int'(repeat_cnt); r++) begin
`ifdef PATTERN_TX_GAP_EN
          if (r > 0) q.push_back(2);
`endif
          for (int b = WIDTH - 1; b >= 0; b--) q.push_back(int'(pattern_in[b]));
        end
        v = q.pop_front();
        exp_valid = 1'b1; exp_data = (v == 1); data_chk = 1'b1;
        m_busy = 1'b1; exp_busy = 1'b1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    model_step();
    #1;
    check_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic start(input logic [WIDTH-1:0] p, input logic [REP_W-1:0] r);
    load = 1'b1; pattern_in = p; repeat_cnt = r;
    tick();
    load = 1'b0;
  endtask

  initial begin
    rst = 1'b0; load = 1'b0; pattern_in = '0; repeat_cnt = '0; hold = 1'b0; abort = 1'b0;
    model_reset();
    #3;
    check_all();
    ticks(2);
    rst = 1'b1;
    ticks(2);

    // single shot
    start(5'b10110, 4'd0);
    ticks(7);

    // repeats
    start(5'b11001, 4'd2);
    ticks(19);

    // hold for three cycles after the second bit
    start(5'b10000, 4'd0);
    tick();
    hold = 1'b1;
    ticks(3);
    hold = 1'b0;
    ticks(6);

    // load while busy is ignored, scrambled inputs mid-transfer have no effect
    start(5'b10110, 4'd1);
    load = 1'b1; pattern_in = 5'b01111; repeat_cnt = 4'd3;
    ticks(3);
    load = 1'b0;
    ticks(10);

    // abort at bit 2, with hold and load also high
    start(5'b11111, 4'd3);
    tick();
    abort = 1'b1; hold = 1'b1; load = 1'b1;
    tick();
    abort = 1'b0; hold = 1'b0; load = 1'b0;
    ticks(4);

    // back-to-back: load during the done cycle
    start(5'b11010, 4'd0);
    ticks(5);
    cmp("b2b_done_seen", done, 1'b1);
    start(5'b00101, 4'd0);
    ticks(7);

    // async reset mid-shift
    start(5'b11011, 4'd1);
    ticks(2);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_all();
    tick();
    #2;
    rst = 1'b1;
    ticks(2);

    // maximum repeat count
    start(5'(($urandom & 5'h1f) | 5'h10), 4'hf);
    ticks(WIDTH * 16 + 3);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      load       = ($urandom_range(0, 3) == 0);
      pattern_in = 5'($urandom);
      repeat_cnt = 4'($urandom_range(0, 3));
      hold       = ($urandom_range(0, 5) == 0);
      abort      = ($urandom_range(0, 39) == 0);
      tick();
    end
    load = 1'b0; hold = 1'b0; abort = 1'b0;
    ticks(30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
